view_input_accumulator: RTL and testbench

- Converts PS/2 mouse packets into the camera view angles `Theta`/`Phi` and a click pulse for the ray-casting pipeline.
- Sits directly upstream of the angle/ray lookup and hit-detection stages.
- Accumulates signed mouse motion between frames, then commits it once per frame through a short multi-cycle sequence.
- The commit scales the motion, wraps `Theta` and clamps `Phi`, so the view is stable for the whole frame render.

---
 rtl/view_input_accumulator_pkg.sv | 21 ++
 rtl/view_input_accumulator_sat_accum16.sv | 35 +++
 rtl/view_input_accumulator.sv | 146 ++++++++++++++
 tb/tb_view_input_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/view_input_accumulator_pkg.sv
// Shared types for the view-angle path: 32.32 fixed point, a 3-vector and the commit FSM states.
package view_input_accumulator_pkg;

  typedef logic signed [63:0] fixed_real;

  typedef struct packed {
    fixed_real x;
    fixed_real y;
    fixed_real z;
  } vector;

  localparam fixed_real DEG360_FX = 64'sd360 <<< 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SCALE = 2'd2,
    WRAP  = 2'd3
  } view_commit_state_t;

endpackage

// File: rtl/view_input_accumulator_sat_accum16.sv
// Saturating 16-bit signed accumulator; clr restarts the sum, and an addend in the same cycle lands on the cleared value.
module sat_accum16 (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic signed [15:0] addend,
  output logic signed [15:0] sum
);

  logic signed [16:0] base;
  logic signed [16:0] wide;
  logic signed [15:0] sat;

  always_comb begin
    base = clr ? 17'sd0 : {sum[15], sum};
    wide = base + {addend[15], addend};
    sat  = wide[15:0];
    // 17-bit result out of 16-bit range when the two top bits disagree.
    if (wide[16] != wide[15]) begin
      sat = wide[16] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (en) begin
      sum <= sat;
    end else if (clr) begin
      sum <= '0;
    end
  end

endmodule

// File: rtl/view_input_accumulator.sv
// Mouse motion to Theta/Phi view angles, committed 4 cycles after a Frame_Clk rise; packets never stall.
// Define VIEW_INPUT_INVERT_Y_EN to negate dy before accumulation.
module view_input_accumulator
  import view_input_accumulator_pkg::*;
#(
  parameter int SENS_SHIFT  = 24,
  parameter int PHI_MIN_DEG = -80,
  parameter int PHI_MAX_DEG = 80
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Frame_Clk,
  input  logic       new_data,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  input  logic       m1,
  output fixed_real  Theta,
  output fixed_real  Phi,
  output logic       Click,
  output logic       Updated
);

  localparam fixed_real PHI_MIN_FX = fixed_real'(PHI_MIN_DEG) <<< 32;
  localparam fixed_real PHI_MAX_FX = fixed_real'(PHI_MAX_DEG) <<< 32;

  view_commit_state_t state, state_nxt;

  logic               frame_q;
  logic               frame_rise;
  logic               clr;
  logic               new_press;
  logic               press_seen;
  logic               m1_prev;
  logic               snap_press;
  logic signed [15:0] add_x, add_y;
  logic signed [15:0] acc_x, acc_y;
  logic signed [15:0] snap_x, snap_y;
  fixed_real          d_theta, d_phi;
  fixed_real          theta_sum, phi_sum;
  fixed_real          theta_wrap, phi_clamp;

  assign frame_rise = Frame_Clk & ~frame_q;
  assign clr        = (state == LATCH);
  assign new_press  = new_data & m1 & ~m1_prev;

  assign add_x = {{7{dx[8]}}, dx};
`ifdef VIEW_INPUT_INVERT_Y_EN
  assign add_y = -{{7{dy[8]}}, dy};
`else
  assign add_y = {{7{dy[8]}}, dy};
`endif

  sat_accum16 u_acc_x (
    .clk    (Clk),
    .rst    (Reset),
    .clr    (clr),
    .en     (new_data),
    .addend (add_x),
    .sum    (acc_x)
  );

  sat_accum16 u_acc_y (
    .clk    (Clk),
    .rst    (Reset),
    .clr    (clr),
    .en     (new_data),
    .addend (add_y),
    .sum    (acc_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_rise) state_nxt = LATCH;
      LATCH:   state_nxt = SCALE;
      SCALE:   state_nxt = WRAP;
      WRAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    d_theta = fixed_real'(snap_x) <<< SENS_SHIFT;
    d_phi   = fixed_real'(snap_y) <<< SENS_SHIFT;

    // A single correction suffices: one frame's delta is well under 360 degrees.
    theta_wrap = theta_sum;
    if (theta_sum < 64'sd0) begin
      theta_wrap = theta_sum + DEG360_FX;
    end else if (theta_sum >= DEG360_FX) begin
      theta_wrap = theta_sum - DEG360_FX;
    end

    phi_clamp = phi_sum;
    if (phi_sum < PHI_MIN_FX) begin
      phi_clamp = PHI_MIN_FX;
    end else if (phi_sum > PHI_MAX_FX) begin
      phi_clamp = PHI_MAX_FX;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      frame_q    <= 1'b0;
      m1_prev    <= 1'b0;
      press_seen <= 1'b0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_press <= 1'b0;
      theta_sum  <= '0;
      phi_sum    <= '0;
      Theta      <= '0;
      Phi        <= '0;
      Click      <= 1'b0;
      Updated    <= 1'b0;
    end else begin
      state   <= state_nxt;
      frame_q <= Frame_Clk;
      if (new_data) m1_prev <= m1;

      // A press arriving in the LATCH cycle belongs to the next frame.
      if (state == LATCH) begin
        press_seen <= new_press;
        snap_x     <= acc_x;
        snap_y     <= acc_y;
        snap_press <= press_seen;
      end else if (new_press) begin
        press_seen <= 1'b1;
      end

      if (state == SCALE) begin
        theta_sum <= Theta + d_theta;
        phi_sum   <= Phi + d_phi;
      end

      if (state == WRAP) begin
        Theta <= theta_wrap;
        Phi   <= phi_clamp;
      end
      Updated <= (state == WRAP);
      Click   <= (state == WRAP) && snap_press;
    end
  end

endmodule

// File: tb/tb_view_input_accumulator.sv
// Directed bench for view_input_accumulator: reset, yaw/wrap, pitch clamp, saturation, click, frame boundary, mid-commit reset.
module tb_view_input_accumulator;

  logic        Clk;
  logic        Reset;
  logic        Frame_Clk;
  logic        new_data;
  logic [8:0]  dx;
  logic [8:0]  dy;
  logic        m1;
  logic [63:0] Theta;
  logic [63:0] Phi;
  logic        Click;
  logic        Updated;

  int          checks;
  int          errors;
  int          upd_cnt;
  int          click_cnt;
  int          upd_at;
  logic [63:0] theta_mid;

  view_input_accumulator dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Frame_Clk (Frame_Clk),
    .new_data  (new_data),
    .dx        (dx),
    .dy        (dy),
    .m1        (m1),
    .Theta     (Theta),
    .Phi       (Phi),
    .Click     (Click),
    .Updated   (Updated)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic b);
    new_data = 1'b1;
    dx       = x[8:0];
    dy       = y[8:0];
    m1       = b;
    tick();
    new_data = 1'b0;
    dx       = '0;
    dy       = '0;
  endtask

  task automatic apply_reset();
    Reset     = 1'b1;
    Frame_Clk = 1'b0;
    new_data  = 1'b0;
    dx        = '0;
    dy        = '0;
    m1        = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Raises Frame_Clk and watches six cycles; optionally drives a packet in the LATCH cycle.
  task automatic frame_commit(input bit inj, input int inj_dx);
    upd_cnt   = 0;
    click_cnt = 0;
    upd_at    = -1;
    Frame_Clk = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1 && inj) begin
        new_data = 1'b1;
        dx       = inj_dx[8:0];
        dy       = '0;
      end
      if (k == 2) begin
        new_data  = 1'b0;
        dx        = '0;
        Frame_Clk = 1'b0;
      end
      if (k == 3) theta_mid = Theta;
      if (Updated) begin
        upd_cnt++;
        if (upd_at < 0) upd_at = k;
      end
      if (Click) click_cnt++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (Theta !== 64'h0) begin errors++; $display("FAIL reset_theta: got %h expected %h", Theta, 64'h0); end
    checks++; if (Phi !== 64'h0) begin errors++; $display("FAIL reset_phi: got %h expected %h", Phi, 64'h0); end
    checks++; if (Click !== 1'b0) begin errors++; $display("FAIL reset_click: got %b expected 0", Click); end
    checks++; if (Updated !== 1'b0) begin errors++; $display("FAIL reset_updated: got %b expected 0", Updated); end
  endtask

  task automatic test_basic_yaw();
    apply_reset();
    send(10, 0, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (theta_mid !== 64'h0) begin errors++; $display("FAIL yaw_theta_early: got %h expected %h", theta_mid, 64'h0); end
    checks++; if (upd_at !== 4) begin errors++; $display("FAIL yaw_latency: got %0d expected 4", upd_at); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL yaw_updated_count: got %0d expected 1", upd_cnt); end
    checks++; if (click_cnt !== 0) begin errors++; $display("FAIL yaw_click_count: got %0d expected 0", click_cnt); end
    checks++; if (Theta !== 64'h0000_0000_0A00_0000) begin errors++; $display("FAIL yaw_theta: got %h expected %h", Theta, 64'h0000_0000_0A00_0000); end
    checks++; if (Phi !== 64'h0) begin errors++; $display("FAIL yaw_phi: got %h expected %h", Phi, 64'h0); end
  endtask

  task automatic test_theta_wrap();
    apply_reset();
    send(-1, 0, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (Theta !== 64'h0000_0167_FF00_0000) begin errors++; $display("FAIL wrap_neg: got %h expected %h", Theta, 64'h0000_0167_FF00_0000); end
    send(2, 0, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (Theta !== 64'h0000_0000_0100_0000) begin errors++; $display("FAIL wrap_pos: got %h expected %h", Theta, 64'h0000_0000_0100_0000); end
  endtask

  task automatic test_phi_clamp();
    logic [63:0] exp1, exp2;
`ifdef VIEW_INPUT_INVERT_Y_EN
    exp1 = 64'hFFFF_FFB0_0000_0000;
    exp2 = 64'hFFFF_FFB5_0000_0000;
`else
    exp1 = 64'h0000_0050_0000_0000;
    exp2 = 64'h0000_004B_0000_0000;
`endif
    apply_reset();
    for (int i = 0; i < 200; i++) send(0, 127, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (Phi !== exp1) begin errors++; $display("FAIL phi_clamp_max: got %h expected %h", Phi, exp1); end
    checks++; if (Theta !== 64'h0) begin errors++; $display("FAIL phi_clamp_theta: got %h expected %h", Theta, 64'h0); end
    for (int i = 0; i < 10; i++) send(0, -128, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (Phi !== exp2) begin errors++; $display("FAIL phi_step_back: got %h expected %h", Phi, exp2); end
  endtask

  task automatic test_saturation();
    logic [63:0] exp_phi;
`ifdef VIEW_INPUT_INVERT_Y_EN
    exp_phi = 64'h0000_0050_0000_0000;
`else
    exp_phi = 64'hFFFF_FFB0_0000_0000;
`endif
    apply_reset();
    for (int i = 0; i < 300; i++) send(255, 0, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (Theta !== 64'h0000_007F_FF00_0000) begin errors++; $display("FAIL sat_pos_theta: got %h expected %h", Theta, 64'h0000_007F_FF00_0000); end
    apply_reset();
    for (int i = 0; i < 300; i++) send(-256, -256, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (Theta !== 64'h0000_00E8_0000_0000) begin errors++; $display("FAIL sat_neg_theta: got %h expected %h", Theta, 64'h0000_00E8_0000_0000); end
    checks++; if (Phi !== exp_phi) begin errors++; $display("FAIL sat_neg_phi: got %h expected %h", Phi, exp_phi); end
  endtask

  task automatic test_click();
    apply_reset();
    send(0, 0, 1'b0);
    send(0, 0, 1'b1);
    frame_commit(1'b0, 0);
    checks++; if (click_cnt !== 1) begin errors++; $display("FAIL click_press: got %0d expected 1", click_cnt); end
    send(0, 0, 1'b1);
    send(0, 0, 1'b1);
    frame_commit(1'b0, 0);
    checks++; if (click_cnt !== 0) begin errors++; $display("FAIL click_held: got %0d expected 0", click_cnt); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL click_held_updated: got %0d expected 1", upd_cnt); end
  endtask

  task automatic test_latch_packet();
    apply_reset();
    frame_commit(1'b1, 5);
    checks++; if (Theta !== 64'h0) begin errors++; $display("FAIL latch_pkt_this_frame: got %h expected %h", Theta, 64'h0); end
    frame_commit(1'b0, 0);
    checks++; if (Theta !== 64'h0000_0000_0500_0000) begin errors++; $display("FAIL latch_pkt_next_frame: got %h expected %h", Theta, 64'h0000_0000_0500_0000); end
  endtask

  task automatic test_reset_mid_commit();
    int upd;
    apply_reset();
    send(10, 4, 1'b0);
    frame_commit(1'b0, 0);
    send(3, 0, 1'b0);
    Frame_Clk = 1'b1;
    tick();
    Frame_Clk = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    upd = 0;
    for (int k = 0; k < 6; k++) begin
      if (Updated) upd++;
      tick();
    end
    checks++; if (upd !== 0) begin errors++; $display("FAIL midreset_updated: got %0d expected 0", upd); end
    checks++; if (Theta !== 64'h0) begin errors++; $display("FAIL midreset_theta: got %h expected %h", Theta, 64'h0); end
    checks++; if (Phi !== 64'h0) begin errors++; $display("FAIL midreset_phi: got %h expected %h", Phi, 64'h0); end
  endtask

  task automatic test_invert_y();
    logic [63:0] exp_phi;
`ifdef VIEW_INPUT_INVERT_Y_EN
    exp_phi = 64'hFFFF_FFFF_FC00_0000;
`else
    exp_phi = 64'h0000_0000_0400_0000;
`endif
    apply_reset();
    send(0, 4, 1'b0);
    frame_commit(1'b0, 0);
    checks++; if (Phi !== exp_phi) begin errors++; $display("FAIL invert_y_phi: got %h expected %h", Phi, exp_phi); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    theta_mid = '0;
    Reset     = 1'b1;
    Frame_Clk = 1'b0;
    new_data  = 1'b0;
    dx        = '0;
    dy        = '0;
    m1        = 1'b0;
    test_reset();
    test_basic_yaw();
    test_theta_wrap();
    test_phi_clamp();
    test_saturation();
    test_click();
    test_latch_packet();
    test_reset_mid_commit();
    test_invert_y();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
